// File: rtl/div_pkg.sv
// Shared encodings and decode helpers for the divide issue controller.
package div_pkg;

   localparam logic [1:0] DIV_S = 2'b00;
   localparam logic [1:0] DIVU  = 2'b01;
   localparam logic [1:0] MOD_S = 2'b10;
   localparam logic [1:0] MODU  = 2'b11;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_e;

   function automatic logic is_mod(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/div_alu.sv
// Radix-4 (two restoring steps per cycle) magnitude divider; result signs are
// fixed combinationally from the live operand inputs.
module div_alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned ITERS = WIDTH / 2;
   localparam int unsigned CW    = $clog2(ITERS + 1);

   logic             neg_a, neg_b;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] qs, rs, qs_nxt, rs_nxt;
   logic [WIDTH:0]   trial;
   logic [CW-1:0]    cnt;

   assign neg_a = is_signed & a[WIDTH-1];
   assign neg_b = is_signed & b[WIDTH-1];
   assign a_mag = neg_a ? -a : a;
   assign b_mag = neg_b ? -b : b;

   always_comb begin
      trial  = '0;
      qs_nxt = qs;
      rs_nxt = rs;
      for (int unsigned i = 0; i < 2; i++) begin
         trial  = {rs_nxt, qs_nxt[WIDTH-1]};
         qs_nxt = {qs_nxt[WIDTH-2:0], 1'b0};
         if (trial >= {1'b0, b_mag}) begin
            trial     = trial - {1'b0, b_mag};
            qs_nxt[0] = 1'b1;
         end
         rs_nxt = trial[WIDTH-1:0];
      end
   end

   // |b|>|a| finishes immediately with q=0, r=|a|.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         qs   <= '0;
         rs   <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            if (b_mag > a_mag) begin
               qs   <= '0;
               rs   <= a_mag;
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               qs  <= a_mag;
               rs  <= '0;
               cnt <= CW'(ITERS);
            end
         end else if (cnt != '0) begin
            qs  <= qs_nxt;
            rs  <= rs_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) done <= 1'b1;
         end
      end
   end

   assign quotient  = (neg_a ^ neg_b) ? -qs : qs;
   assign remainder = neg_a ? -rs : rs;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer: latches operands, short-circuits trivial cases and
// a one-entry result cache, and drains divides it cannot abort on flush.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 32,
   parameter bit          CACHE_EN  = 1'b1
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_rstn,
   input  logic                 op_valid,
   input  logic [1:0]           op_code,
   input  logic [DIV_WIDTH-1:0] src_a,
   input  logic [DIV_WIDTH-1:0] src_b,
   input  logic                 flush,
   input  logic                 ex_go,
   output logic                 stall,
   output logic                 result_valid,
   output logic [DIV_WIDTH-1:0] result,
   output logic                 busy
);

   div_state_e           state, state_nxt;
   logic [DIV_WIDTH-1:0] op_a, op_b, result_r;
   logic                 op_s, op_rem;
   logic                 cache_v, cache_s;
   logic [DIV_WIDTH-1:0] cache_a, cache_b, cache_q, cache_r;
   logic                 div_start, div_done;
   logic [DIV_WIDTH-1:0] alu_q, alu_r;
   logic                 in_s, in_rem, b_zero, ovf, hit, fast, start_op;
   logic [DIV_WIDTH-1:0] fast_res;

   div_alu #(.WIDTH(DIV_WIDTH)) u_div_alu (
      .clk       (cpu_clk),
      .rstn      (cpu_rstn),
      .start     (div_start),
      .is_signed (op_s),
      .a         (op_a),
      .b         (op_b),
      .done      (div_done),
      .quotient  (alu_q),
      .remainder (alu_r)
   );

   assign in_s     = is_signed(op_code);
   assign in_rem   = is_mod(op_code);
   assign b_zero   = (src_b == '0);
   assign ovf      = in_s & (src_a == INT_MIN) & (src_b == '1);
   assign hit      = CACHE_EN & cache_v & (cache_a == src_a) & (cache_b == src_b) & (cache_s == in_s);
   assign fast     = b_zero | ovf | hit;
   assign start_op = (state == ST_IDLE) & op_valid & ~flush;

   always_comb begin
      fast_res = '0;
      if (b_zero)   fast_res = in_rem ? src_a : '1;
      else if (ovf) fast_res = in_rem ? '0 : INT_MIN;
      else          fast_res = in_rem ? cache_r : cache_q;
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   // A flush coinciding with div_done leaves nothing to drain.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_op) state_nxt = fast ? ST_DONE : ST_ISSUE;
         ST_ISSUE: state_nxt = flush ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (flush)         state_nxt = div_done ? ST_IDLE : ST_DRAIN;
            else if (div_done) state_nxt = ST_DONE;
         end
         ST_DONE:  if (flush || ex_go) state_nxt = ST_IDLE;
         ST_DRAIN: if (div_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      result_valid = 1'b0;
      busy         = 1'b0;
      div_start    = 1'b0;
      stall        = 1'b0;
      result_valid = (state == ST_DONE);
      busy         = (state != ST_IDLE);
      div_start    = (state == ST_ISSUE);
      stall        = op_valid & ~result_valid;
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         op_a     <= '0;
         op_b     <= '0;
         op_s     <= 1'b0;
         op_rem   <= 1'b0;
         result_r <= '0;
         cache_v  <= 1'b0;
         cache_s  <= 1'b0;
         cache_a  <= '0;
         cache_b  <= '0;
         cache_q  <= '0;
         cache_r  <= '0;
      end else begin
         if (start_op) begin
            op_a   <= src_a;
            op_b   <= src_b;
            op_s   <= in_s;
            op_rem <= in_rem;
            if (fast) result_r <= fast_res;
         end
         if ((state == ST_WAIT) && div_done && !flush) begin
            result_r <= op_rem ? alu_r : alu_q;
            if (CACHE_EN) begin
               cache_v <= 1'b1;
               cache_s <= op_s;
               cache_a <= op_a;
               cache_b <= op_b;
               cache_q <= alu_q;
               cache_r <= alu_r;
            end
         end
      end
   end

   assign result = result_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed and randomized checks of div_issue_ctrl against an arithmetic
// reference model with a one-entry cache predictor.
module tb_div_issue_ctrl;
   import div_pkg::*;

   logic        cpu_clk  = 1'b0;
   logic        cpu_rstn = 1'b0;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code  = 2'b00;
   logic [31:0] src_a    = '0;
   logic [31:0] src_b    = '0;
   logic        flush    = 1'b0;
   logic        ex_go    = 1'b0;
   logic        stall, result_valid, busy;
   logic [31:0] result;

   int vectors     = 0;
   int miscompares = 0;
   int starts      = 0;

   bit          mc_valid = 1'b0;
   bit          mc_s     = 1'b0;
   logic [31:0] mc_a     = '0;
   logic [31:0] mc_b     = '0;

   div_issue_ctrl #(.DIV_WIDTH(32), .CACHE_EN(1'b1)) u_dut (
      .cpu_clk      (cpu_clk),
      .cpu_rstn     (cpu_rstn),
      .op_valid     (op_valid),
      .op_code      (op_code),
      .src_a        (src_a),
      .src_b        (src_b),
      .flush        (flush),
      .ex_go        (ex_go),
      .stall        (stall),
      .result_valid (result_valid),
      .result       (result),
      .busy         (busy)
   );

   always #5 cpu_clk = ~cpu_clk;

   always @(negedge cpu_clk) if (u_dut.div_start === 1'b1) starts++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   function automatic bit sgn_op(input logic [1:0] code);
      return (code == DIV_S) || (code == MOD_S);
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] code, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic [31:0] q, r;
      sa = a;
      sb = b;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (sgn_op(code) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0;
      end else if (sgn_op(code)) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
      return (code == MOD_S || code == MODU) ? r : q;
   endfunction

   function automatic bit ref_fast(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return 1'b1;
      if (sgn_op(code) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      return mc_valid && mc_a == a && mc_b == b && mc_s == sgn_op(code);
   endfunction

   task automatic wait_idle(input string tag, input int max_cyc, output int cyc, output bit saw_rv);
      cyc = 0;
      saw_rv = 1'b0;
      while (busy === 1'b1 && cyc < max_cyc) begin
         @(posedge cpu_clk); #1;
         cyc++;
         if (result_valid === 1'b1) saw_rv = 1'b1;
      end
      check({tag, "_idle"}, busy, 0);
      check({tag, "_no_rv"}, saw_rv, 0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                         input logic [31:0] b, input bit end_flush);
      logic [31:0] exp;
      bit fast;
      int lat, s0;
      exp  = ref_result(code, a, b);
      fast = ref_fast(code, a, b);
      @(negedge cpu_clk);
      s0 = starts;
      op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
      lat = 0;
      do begin
         @(posedge cpu_clk); #1;
         lat++;
         src_a = $urandom; src_b = $urandom; op_code = 2'($urandom_range(0, 3));
         if (lat == 1 && !fast) check({tag, "_stall"}, stall, 1);
      end while (result_valid !== 1'b1 && lat < 40);
      check({tag, "_rv"}, result_valid, 1);
      check({tag, "_res"}, result, exp);
      if (fast) check({tag, "_lat"}, lat, 1);
      else      check({tag, "_lat_rng"}, 32'(lat >= 3 && lat <= 19), 1);
      check({tag, "_starts"}, starts - s0, fast ? 0 : 1);
      check({tag, "_stall_lo"}, stall, 0);
      if (end_flush) flush = 1'b1; else ex_go = 1'b1;
      @(posedge cpu_clk); #1;
      flush = 1'b0; ex_go = 1'b0; op_valid = 1'b0;
      check({tag, "_rv_clr"}, result_valid, 0);
      check({tag, "_busy_clr"}, busy, 0);
      if (!fast) begin
         mc_valid = 1'b1; mc_a = a; mc_b = b; mc_s = sgn_op(code);
      end
   endtask

   initial begin
      int s0, cyc;
      bit saw_rv;
      logic [31:0] ra, rb, pa, pb;
      logic [1:0] rc;

      #1;
      check("rst_busy", busy, 0);
      check("rst_rv", result_valid, 0);
      check("rst_stall", stall, 0);
      check("rst_result", result, 0);
      repeat (2) @(negedge cpu_clk);
      cpu_rstn = 1'b1;

      run_op("divu_100_7", DIVU, 100, 7, 1'b0);
      run_op("modu_100_7_hit", MODU, 100, 7, 1'b0);
      run_op("div_m7_2", DIV_S, 32'hFFFF_FFF9, 2, 1'b0);
      run_op("mod_m7_2", MOD_S, 32'hFFFF_FFF9, 2, 1'b0);
      run_op("modu_sgn_miss", MODU, 32'hFFFF_FFF9, 2, 1'b0);
      run_op("div_5_0", DIV_S, 5, 0, 1'b0);
      run_op("mod_5_0", MOD_S, 5, 0, 1'b0);
      run_op("div_ovf", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("mod_ovf", MOD_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_min_m1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("div_min_1", DIV_S, 32'h8000_0000, 1, 1'b0);

      // flush while IDLE with op_valid: nothing issued
      @(negedge cpu_clk);
      s0 = starts;
      op_valid = 1'b1; op_code = DIVU; src_a = 50; src_b = 5; flush = 1'b1;
      @(posedge cpu_clk); #1;
      check("flush_idle_busy", busy, 0);
      check("flush_idle_rv", result_valid, 0);
      flush = 1'b0; op_valid = 1'b0;
      @(negedge cpu_clk);
      check("flush_idle_starts", starts - s0, 0);

      // longest divide flushed 3 cycles after issue
      @(negedge cpu_clk);
      s0 = starts;
      op_valid = 1'b1; op_code = DIVU; src_a = 32'hFFFF_FFFF; src_b = 1;
      @(posedge cpu_clk); #1;
      @(posedge cpu_clk); #1;
      repeat (3) @(posedge cpu_clk);
      #1;
      flush = 1'b1; op_valid = 1'b0;
      @(posedge cpu_clk); #1;
      flush = 1'b0;
      check("drain_busy", busy, 1);
      check("drain_starts", starts - s0, 1);
      wait_idle("drain_long", 30, cyc, saw_rv);
      check("drain_len", 32'(cyc >= 10 && cyc <= 15), 1);
      run_op("divu_9_3", DIVU, 9, 3, 1'b0);
      run_op("divu_max_1_miss", DIVU, 32'hFFFF_FFFF, 1, 1'b0);

      // flush during ISSUE still sends the start pulse
      @(negedge cpu_clk);
      s0 = starts;
      op_valid = 1'b1; op_code = DIVU; src_a = 3; src_b = 10;
      @(posedge cpu_clk); #1;
      flush = 1'b1; op_valid = 1'b0;
      @(posedge cpu_clk); #1;
      flush = 1'b0;
      check("flush_issue_busy", busy, 1);
      check("flush_issue_starts", starts - s0, 1);
      wait_idle("flush_issue", 30, cyc, saw_rv);
      run_op("divu_3_10_miss", DIVU, 3, 10, 1'b0);

      // reset mid-WAIT
      run_op("divu_8_2_pre", DIVU, 8, 2, 1'b0);
      @(negedge cpu_clk);
      op_valid = 1'b1; op_code = DIVU; src_a = 32'hFFFF_FFFF; src_b = 3;
      repeat (5) @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rstn = 1'b0; op_valid = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rv", result_valid, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_result", result, 0);
      mc_valid = 1'b0;
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      run_op("divu_8_2_post", DIVU, 8, 2, 1'b0);

      // randomized ops, with deliberate operand repeats to exercise the cache
      pa = 100; pb = 7;
      for (int i = 0; i < 60; i++) begin
         rc = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: ra = $urandom;
            1: ra = $urandom_range(0, 300);
            2: begin
               ra = $urandom_range(0, 3);
               ra = (ra == 0) ? 32'h0 : (ra == 1) ? 32'h8000_0000 : (ra == 2) ? 32'hFFFF_FFFF : 32'h1;
            end
            default: ra = pa;
         endcase
         case ($urandom_range(0, 5))
            0: rb = $urandom;
            1: rb = $urandom_range(1, 20);
            2: rb = 32'hFFFF_FFFF;
            3: rb = 0;
            4: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: rb = pb;
         endcase
         run_op($sformatf("rnd%0d", i), rc, ra, rb, ($urandom_range(0, 7) == 0));
         pa = ra; pb = rb;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
